// File: rtl/scroll_motion_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : scroll_motion_controller_if
// Purpose  : Valid/ready configuration channel that carries the velocity
//            limits into scroll_motion_controller.
// Signals  : cfg_valid  - new limits offered (master -> slave)
//            cfg_ready  - limits can be accepted this cycle (slave -> master)
//            cfg_vmax   - signed upper velocity limit (master -> slave)
//            cfg_vmin   - signed lower velocity limit (master -> slave)
//            cfg_err    - one-cycle reject pulse (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface scroll_motion_controller_if #(
  parameter int VEL_W = 8
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [VEL_W-1:0] cfg_vmax;
  logic [VEL_W-1:0] cfg_vmin;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_vmax,
    output cfg_vmin,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_vmax,
    input  cfg_vmin,
    output cfg_ready,
    output cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/scroll_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : scroll_motion_controller
// Purpose  : Per-frame motion sequencer for the VGA pattern scroller. Detects
//            the vsync rising edge, steps a signed velocity through a
//            ramp-up / hold / ramp-down / hold profile and accumulates a
//            wrapping horizontal scroll offset.
// Ports    : clk        - pixel clock
//            reset      - synchronous, active-high reset
//            vsync      - vsync from hvsync_generator (rising edge = frame)
//            pause      - level; freezes motion while high
//            step       - single-step request (only with
//                         SCROLL_SINGLE_STEP_EN defined)
//            cfg        - limit configuration channel (slave modport)
//            offset     - scroll offset, modulo 2^OFFSET_W
//            velocity   - current signed velocity
//            state      - 00 RAMP_UP, 01 HOLD_HI, 10 RAMP_DOWN, 11 HOLD_LO
//            frame_tick - one-cycle pulse after each detected frame edge
// Options  : SCROLL_SINGLE_STEP_EN - adds the step port and a one-shot flag
//            that lets a single tick update while paused.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_motion_controller #(
  parameter int OFFSET_W    = 10,
  parameter int VEL_W       = 8,
  parameter int VEL_MAX_RST = 20,
  parameter int VEL_MIN_RST = -10,
  parameter int HOLD_FRAMES = 8
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                vsync,
  input  wire logic                pause,
`ifdef SCROLL_SINGLE_STEP_EN
  input  wire logic                step,
`endif
  scroll_motion_controller_if.slave cfg,
  output logic      [OFFSET_W-1:0] offset,
  output logic      [VEL_W-1:0]    velocity,
  output logic      [1:0]          state,
  output logic                     frame_tick
);

  localparam int                   c_DWELL_W   = 8;
  localparam logic [c_DWELL_W-1:0] c_HOLD      = c_DWELL_W'(HOLD_FRAMES);
  localparam logic [c_DWELL_W-1:0] c_DWELL_ONE = {{(c_DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [VEL_W-1:0]     c_VEL_ONE   = {{(VEL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RAMP_UP   = 2'b00,
    ST_HOLD_HI   = 2'b01,
    ST_RAMP_DOWN = 2'b10,
    ST_HOLD_LO   = 2'b11
  } state_t;

  // Registered state
  logic                 r_vsync_q;
  logic                 r_frame_tick;
  logic                 r_cfg_err;
  logic [VEL_W-1:0]     r_vmax;
  logic [VEL_W-1:0]     r_vmin;
  logic [OFFSET_W-1:0]  r_offset;
  logic [VEL_W-1:0]     r_velocity;
  state_t               r_state;
  logic [c_DWELL_W-1:0] r_dwell;

  // Combinational next-state
  logic                 w_tick;
  logic                 w_update;
  logic                 w_cfg_fire;
  logic                 w_cfg_ok;
  logic [OFFSET_W-1:0]  w_vel_ext;
  logic [OFFSET_W-1:0]  w_offset_nxt;
  logic [VEL_W-1:0]     w_velocity_nxt;
  state_t               w_state_nxt;
  logic [c_DWELL_W-1:0] w_dwell_nxt;

  // Frame edge: high for the single cycle where vsync has just risen.
  assign w_tick = vsync & ~r_vsync_q;

  // The motion update owns the tick cycle, so config is refused then.
  assign cfg.cfg_ready = ~w_tick;
  assign w_cfg_fire    = cfg.cfg_valid & ~w_tick;
  assign w_cfg_ok      = $signed(cfg.cfg_vmin) < $signed(cfg.cfg_vmax);

`ifdef SCROLL_SINGLE_STEP_EN
  logic r_step_armed;

  // While paused, a step arms one update; the tick that consumes it clears
  // it. Releasing pause drops any stale request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_armed <= 1'b0;
    end else if (!pause) begin
      r_step_armed <= 1'b0;
    end else if (w_tick && r_step_armed) begin
      r_step_armed <= 1'b0;
    end else if (step) begin
      r_step_armed <= 1'b1;
    end
  end

  assign w_update = w_tick & (~pause | r_step_armed);
`else
  assign w_update = w_tick & ~pause;
`endif

  // Sign-extend velocity to the offset width; the add then wraps naturally.
  assign w_vel_ext = OFFSET_W'($signed(r_velocity));

  always_comb begin
    w_offset_nxt   = r_offset;
    w_velocity_nxt = r_velocity;
    w_state_nxt    = r_state;
    w_dwell_nxt    = r_dwell;
    if (w_update) begin
      w_offset_nxt = r_offset + w_vel_ext;
      case (r_state)
        ST_RAMP_UP: begin
          // >= also catches a velocity left above a freshly lowered limit.
          if ($signed(r_velocity) >= $signed(r_vmax)) begin
            w_velocity_nxt = r_vmax;
            w_state_nxt    = ST_HOLD_HI;
            w_dwell_nxt    = c_HOLD;
          end else begin
            w_velocity_nxt = r_velocity + c_VEL_ONE;
          end
        end
        ST_HOLD_HI: begin
          if (r_dwell == '0) begin
            w_state_nxt    = ST_RAMP_DOWN;
            w_velocity_nxt = r_velocity - c_VEL_ONE;
          end else begin
            w_dwell_nxt = r_dwell - c_DWELL_ONE;
          end
        end
        ST_RAMP_DOWN: begin
          if ($signed(r_velocity) <= $signed(r_vmin)) begin
            w_velocity_nxt = r_vmin;
            w_state_nxt    = ST_HOLD_LO;
            w_dwell_nxt    = c_HOLD;
          end else begin
            w_velocity_nxt = r_velocity - c_VEL_ONE;
          end
        end
        default: begin // ST_HOLD_LO
          if (r_dwell == '0) begin
            w_state_nxt    = ST_RAMP_UP;
            w_velocity_nxt = r_velocity + c_VEL_ONE;
          end else begin
            w_dwell_nxt = r_dwell - c_DWELL_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // vsync_q resets high so a vsync already high at release is not a tick.
      r_vsync_q    <= 1'b1;
      r_frame_tick <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_vmax       <= VEL_W'(VEL_MAX_RST);
      r_vmin       <= VEL_W'(VEL_MIN_RST);
      r_offset     <= '0;
      r_velocity   <= '0;
      r_state      <= ST_RAMP_UP;
      r_dwell      <= '0;
    end else begin
      r_vsync_q    <= vsync;
      r_frame_tick <= w_tick;
      r_cfg_err    <= w_cfg_fire & ~w_cfg_ok;
      if (w_cfg_fire && w_cfg_ok) begin
        r_vmax <= cfg.cfg_vmax;
        r_vmin <= cfg.cfg_vmin;
      end
      r_offset   <= w_offset_nxt;
      r_velocity <= w_velocity_nxt;
      r_state    <= w_state_nxt;
      r_dwell    <= w_dwell_nxt;
    end
  end

  assign offset      = r_offset;
  assign velocity    = r_velocity;
  assign state       = r_state;
  assign frame_tick  = r_frame_tick;
  assign cfg.cfg_err = r_cfg_err;

endmodule
`default_nettype wire
